crt_io_seq: RTL
===============

Name: crt_io_seq

Overview:
Host I/O access sequencer for the CRT controller register file.
- Decodes the CRTC index/data ports (3B4/3B5, 3D4/3D5) and the status ports (3BA/3DA) according to color_mode.
- Owns the CRTC index register.
- Splits 16-bit index+data writes into ordered index-then-data steps.
- Applies CR11[7] write protection and produces one-cycle register write strobes and read-back data, completed by a single-cycle ack handshake.
- Sits between the host I/O bus and the CRT register/extension blocks.

Parameters:
INDEX_W, 6, width of CRTC index register (index bits above INDEX_W are discarded)
WP_LAST, 7, highest index covered by CR11[7] write protect

Ports:
h_hclk  in  1  host clock
h_reset_n  in  1  reset
h_iowr  in  1  I/O write request, level, held until h_io_ack
h_iord  in  1  I/O read request, level, held until h_io_ack
h_io_16  in  1  1 = 16-bit access, 0 = 8-bit
h_addr  in  16  host I/O address
h_io_dbus  in  16  host write data
color_mode  in  1  1 = 3Dx ports active, 0 = 3Bx ports active
cr11_b7  in  1  CRTC write-protect bit
crt_rd_data  in  8  register-file data for crt_rd_index, combinational
reg_ins1  in  8  input status 1 value
c_crtc_index  out  INDEX_W  current CRTC index
crt_wr_en  out  1  one-cycle register write strobe
crt_wr_index  out  INDEX_W  target index for write
crt_wr_data  out  8  write data
crt_wr_mask  out  8  per-bit write enable accompanying crt_wr_en
crt_rd_index  out  INDEX_W  read index to register file
h_rd_data  out  16  read data, valid while h_io_ack
h_io_ack  out  1  one-cycle access completion
attr_ff_clr  out  1  one-cycle pulse: clear attribute address/data flip-flop

Behaviour:
- Reset is asynchronous, active-low on h_reset_n; clock is h_hclk.
- Reset values: state IDLE, c_crtc_index 0, all strobes 0, h_rd_data 0, crt_wr_* 0, crt_rd_index 0.
- States: IDLE, WR_IDX, WR_DAT, RD_DAT, ACK.
- IDLE: request sampled every edge.
  - h_iowr has priority: if h_iowr and h_iord are both high, the access is a write.
  - Active index-port write: go to WR_IDX.
  - Active data-port write: go to WR_DAT.
  - Active read: go to RD_DAT.
  - Any other access (inactive-mode port, status-port write, unrelated address): go straight to ACK with no side effects; h_rd_data = 16'hFFFF for reads.
- WR_IDX: c_crtc_index <= h_io_dbus[INDEX_W-1:0] at exit edge.
  - If h_io_16, go to WR_DAT and use data byte h_io_dbus[15:8] with the newly loaded index.
  - Else go to ACK.
- WR_DAT: crt_wr_en high for exactly this cycle; crt_wr_index = c_crtc_index.
  - crt_wr_data = h_io_dbus[15:8] if entered from WR_IDX, else h_io_dbus[7:0].
  - crt_wr_mask = 8'hFF, except:
    - cr11_b7 = 1 and index < WP_LAST: crt_wr_en suppressed (stays 0), mask 8'h00.
    - cr11_b7 = 1 and index == WP_LAST: crt_wr_en asserted, mask 8'h10 (line-compare bit 4 stays writable).
  - Then go to ACK.
- RD_DAT: crt_rd_index = c_crtc_index; h_rd_data captured at exit edge.
  - Index port, 8-bit: {8'hFF, 2'b00, index}.
  - Index port, 16-bit: {crt_rd_data, 2'b00, index}.
  - Data port: {8'hFF, crt_rd_data}.
  - Status port: {8'hFF, reg_ins1}; attr_ff_clr pulses in this cycle.
  - Then go to ACK.
- ACK: h_io_ack = 1 for one cycle; request inputs ignored; return to IDLE. The requester must drop its request before the IDLE sample after ack; a still-high request starts a new access.
- Latency from the IDLE sampling edge: 8-bit index write ack in cycle 2; 16-bit index write ack in cycle 3 (wr_en in cycle 2); data write ack in cycle 2; read ack in cycle 2.
- Inputs (h_addr, h_io_16, h_io_dbus, color_mode) must be stable from request until ack.
- A color_mode change mid-access is ignored; the port decode is latched at IDLE.
- Reset mid-access: return to IDLE immediately; no ack, no strobe.

Decomposition:
- Shared package crt_pkg:
  - Port constants CRT_IDX_MONO = 16'h03B4, CRT_DAT_MONO = 16'h03B5, STAT_MONO = 16'h03BA, CRT_IDX_COLR = 16'h03D4, CRT_DAT_COLR = 16'h03D5, STAT_COLR = 16'h03DA.
  - State enum crt_seq_state_t.
  - CR07 protect mask constant 8'h10.
- One natural sub-module: crt_port_dec, combinational h_addr + color_mode -> {is_idx, is_dat, is_stat, active}.

Test Plan:
1. color_mode = 1, 8-bit write 3D4 = 8'h12, then 8-bit write 3D5 = 8'h5A -> c_crtc_index = 6'h12; crt_wr_en one cycle with index 12, data 5A, mask FF; two acks.
2. color_mode = 1, 16-bit write 3D4 with dbus = 16'h8F09 -> index 09, then crt_wr_en index 09, data 8F, in the cycle before ack.
3. cr11_b7 = 1: write CR03 = 8'hAA -> no crt_wr_en, ack still given. Write CR07 = 8'hFF -> crt_wr_en with mask 8'h10. Write CR08 = 8'h01 -> mask FF.
4. color_mode = 0: write 3D5 -> no strobe, index unchanged, ack. Read 3D5 -> h_rd_data = 16'hFFFF.
5. color_mode = 1, read 3DA with reg_ins1 = 8'h09 -> attr_ff_clr pulse, h_rd_data = 16'hFF09. 16-bit read 3D4 with index 11, crt_rd_data = 8'h80 -> 16'h8011.
6. Assert h_reset_n low during WR_DAT of a 16-bit write -> no wr_en, no ack, index = 0, state IDLE. Simultaneous h_iowr + h_iord -> write performed.

Source files
------------

// File: rtl/crt_pkg.sv
// Shared constants and types for the CRTC host I/O sequencer.
//   - I/O port addresses for monochrome (3Bx) and color (3Dx) modes
//   - sequencer state encoding
//   - write-mask and read-fill constants
package crt_pkg;

  localparam logic [15:0] CRT_IDX_MONO = 16'h03B4;
  localparam logic [15:0] CRT_DAT_MONO = 16'h03B5;
  localparam logic [15:0] STAT_MONO    = 16'h03BA;
  localparam logic [15:0] CRT_IDX_COLR = 16'h03D4;
  localparam logic [15:0] CRT_DAT_COLR = 16'h03D5;
  localparam logic [15:0] STAT_COLR    = 16'h03DA;

  // CR07 stays partially writable under CR11[7]: only line-compare bit 4
  localparam logic [7:0]  CR07_PROT_MASK = 8'h10;
  localparam logic [7:0]  WR_MASK_ALL    = 8'hFF;
  localparam logic [7:0]  WR_MASK_NONE   = 8'h00;

  // Undriven byte lanes and unclaimed reads float high on the host bus
  localparam logic [7:0]  RD_FILL  = 8'hFF;
  localparam logic [15:0] RD_FLOAT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    WR_IDX,
    WR_DAT,
    RD_DAT,
    ACK
  } crt_seq_state_t;

endpackage

// File: rtl/crt_io_seq_if.sv
// Host I/O bus between the requester (master) and the CRTC sequencer (slave).
//   h_iowr/h_iord : level requests, held until h_io_ack
//   h_io_16       : 16-bit access
//   h_addr        : I/O address
//   h_io_dbus     : write data
//   h_rd_data     : read data, valid while h_io_ack
//   h_io_ack      : one-cycle completion
interface crt_io_seq_if;

  logic        h_iowr;
  logic        h_iord;
  logic        h_io_16;
  logic [15:0] h_addr;
  logic [15:0] h_io_dbus;
  logic [15:0] h_rd_data;
  logic        h_io_ack;

  modport master (
    output h_iowr, h_iord, h_io_16, h_addr, h_io_dbus,
    input  h_rd_data, h_io_ack
  );

  modport slave (
    input  h_iowr, h_iord, h_io_16, h_addr, h_io_dbus,
    output h_rd_data, h_io_ack
  );

endinterface

// File: rtl/crt_port_dec.sv
// Combinational CRTC port decoder.
//   h_addr, color_mode -> is_idx_c / is_dat_c / is_stat_c for the port set
//   selected by color_mode; active_c when any of them matches.
module crt_port_dec
  import crt_pkg::*;
(
  input  logic [15:0] h_addr,
  input  logic        color_mode,
  output logic        is_idx_c,
  output logic        is_dat_c,
  output logic        is_stat_c,
  output logic        active_c
);

  logic [15:0] idx_port;
  logic [15:0] dat_port;
  logic [15:0] stat_port;

  // Only the port set of the current display mode responds
  always_comb begin
    idx_port  = color_mode ? CRT_IDX_COLR : CRT_IDX_MONO;
    dat_port  = color_mode ? CRT_DAT_COLR : CRT_DAT_MONO;
    stat_port = color_mode ? STAT_COLR    : STAT_MONO;
    is_idx_c  = (h_addr == idx_port);
    is_dat_c  = (h_addr == dat_port);
    is_stat_c = (h_addr == stat_port);
    active_c  = is_idx_c | is_dat_c | is_stat_c;
  end

endmodule

// File: rtl/crt_io_seq.sv
// Host I/O access sequencer for the CRT controller register file.
//   h_hclk, h_reset_n : clock, async active-low reset
//   host              : host I/O bus (slave side)
//   color_mode        : selects 3Dx (1) or 3Bx (0) ports
//   cr11_b7           : CRTC write protect for CR00..CR(WP_LAST)
//   crt_rd_data       : register-file data for crt_rd_index
//   reg_ins1          : input status 1 value
//   c_crtc_index      : CRTC index register
//   crt_wr_en/index/data/mask : one-cycle register write
//   crt_rd_index      : read index to register file
//   attr_ff_clr       : pulse on status read, clears attribute flip-flop
module crt_io_seq
  import crt_pkg::*;
#(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned WP_LAST = 7
) (
  input  logic               h_hclk,
  input  logic               h_reset_n,
  crt_io_seq_if.slave        host,
  input  logic               color_mode,
  input  logic               cr11_b7,
  input  logic [7:0]         crt_rd_data,
  input  logic [7:0]         reg_ins1,
  output logic [INDEX_W-1:0] c_crtc_index,
  output logic               crt_wr_en,
  output logic [INDEX_W-1:0] crt_wr_index,
  output logic [7:0]         crt_wr_data,
  output logic [7:0]         crt_wr_mask,
  output logic [INDEX_W-1:0] crt_rd_index,
  output logic               attr_ff_clr
);

  localparam logic [INDEX_W-1:0] WP_IDX = INDEX_W'(WP_LAST);

  logic is_idx_c;
  logic is_dat_c;
  logic is_stat_c;
  logic active_c;

  crt_port_dec u_port_dec (
    .h_addr     (host.h_addr),
    .color_mode (color_mode),
    .is_idx_c   (is_idx_c),
    .is_dat_c   (is_dat_c),
    .is_stat_c  (is_stat_c),
    .active_c   (active_c)
  );

  crt_seq_state_t     state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic               rd_is_idx_q, rd_is_idx_d;
  logic               rd_is_stat_q, rd_is_stat_d;
  logic               wr_en_q, wr_en_d;
  logic [INDEX_W-1:0] wr_index_q, wr_index_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic [7:0]         wr_mask_q, wr_mask_d;
  logic [INDEX_W-1:0] rd_index_q, rd_index_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               ack_q, ack_d;
  logic               attr_clr_q, attr_clr_d;

  // Register-write setup, evaluated on the edge that enters WR_DAT
  logic               wr_load;
  logic [INDEX_W-1:0] wr_tgt_idx;
  logic [7:0]         wr_tgt_byte;

  // State register and registered outputs
  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rd_is_idx_q  <= 1'b0;
      rd_is_stat_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_index_q   <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
      rd_index_q   <= '0;
      rd_data_q    <= '0;
      ack_q        <= 1'b0;
      attr_clr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_is_idx_q  <= rd_is_idx_d;
      rd_is_stat_q <= rd_is_stat_d;
      wr_en_q      <= wr_en_d;
      wr_index_q   <= wr_index_d;
      wr_data_q    <= wr_data_d;
      wr_mask_q    <= wr_mask_d;
      rd_index_q   <= rd_index_d;
      rd_data_q    <= rd_data_d;
      ack_q        <= ack_d;
      attr_clr_q   <= attr_clr_d;
    end
  end

  // Next-state and next-output logic; strobes are computed one edge ahead
  // so they are high exactly while the FSM sits in the matching state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_is_idx_d  = rd_is_idx_q;
    rd_is_stat_d = rd_is_stat_q;
    wr_en_d      = 1'b0;
    wr_index_d   = wr_index_q;
    wr_data_d    = wr_data_q;
    wr_mask_d    = wr_mask_q;
    rd_index_d   = rd_index_q;
    rd_data_d    = rd_data_q;
    ack_d        = 1'b0;
    attr_clr_d   = 1'b0;
    wr_load      = 1'b0;
    wr_tgt_idx   = idx_q;
    wr_tgt_byte  = host.h_io_dbus[7:0];

    unique case (state_q)
      IDLE: begin
        if (host.h_iowr) begin
          // Write wins when both requests are raised
          if (is_idx_c) begin
            state_d = WR_IDX;
          end else if (is_dat_c) begin
            state_d = WR_DAT;
            wr_load = 1'b1;
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end else if (host.h_iord) begin
          if (active_c) begin
            state_d      = RD_DAT;
            rd_is_idx_d  = is_idx_c;
            rd_is_stat_d = is_stat_c;
            rd_index_d   = idx_q;
            attr_clr_d   = is_stat_c;
          end else begin
            state_d   = ACK;
            ack_d     = 1'b1;
            rd_data_d = RD_FLOAT;
          end
        end
      end

      WR_IDX: begin
        idx_d = host.h_io_dbus[INDEX_W-1:0];
        if (host.h_io_16) begin
          // High byte is data for the index just loaded
          state_d     = WR_DAT;
          wr_load     = 1'b1;
          wr_tgt_idx  = idx_d;
          wr_tgt_byte = host.h_io_dbus[15:8];
        end else begin
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end

      WR_DAT: begin
        state_d = ACK;
        ack_d   = 1'b1;
      end

      RD_DAT: begin
        state_d = ACK;
        ack_d   = 1'b1;
        if (rd_is_stat_q) begin
          rd_data_d = {RD_FILL, reg_ins1};
        end else if (rd_is_idx_q) begin
          rd_data_d = {(host.h_io_16 ? crt_rd_data : RD_FILL), 8'(idx_q)};
        end else begin
          rd_data_d = {RD_FILL, crt_rd_data};
        end
      end

      ACK: begin
        state_d   = IDLE;
        rd_data_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // CR11[7] protection: low indices locked, WP_LAST keeps bit 4 writable
    if (wr_load) begin
      wr_index_d = wr_tgt_idx;
      wr_data_d  = wr_tgt_byte;
      if (cr11_b7 && (wr_tgt_idx < WP_IDX)) begin
        wr_en_d   = 1'b0;
        wr_mask_d = WR_MASK_NONE;
      end else if (cr11_b7 && (wr_tgt_idx == WP_IDX)) begin
        wr_en_d   = 1'b1;
        wr_mask_d = CR07_PROT_MASK;
      end else begin
        wr_en_d   = 1'b1;
        wr_mask_d = WR_MASK_ALL;
      end
    end
  end

  assign c_crtc_index   = idx_q;
  assign crt_wr_en      = wr_en_q;
  assign crt_wr_index   = wr_index_q;
  assign crt_wr_data    = wr_data_q;
  assign crt_wr_mask    = wr_mask_q;
  assign crt_rd_index   = rd_index_q;
  assign attr_ff_clr    = attr_clr_q;
  assign host.h_rd_data = rd_data_q;
  assign host.h_io_ack  = ack_q;

endmodule
